// File: rtl/bft_client_injector.sv
// Synthetic leaf traffic source for the BFT NoC: emits LIMIT packets of PKT_LEN flits,
// rate-limited by a percent accumulator, with destinations chosen by PAT.
module bft_client_injector #(
    parameter int          N       = 2,
    parameter int          D_W     = 32,
    parameter int          A_W     = $clog2(N) + 1,
    parameter int          POSX    = 0,
    parameter int          LIMIT   = 1024,
    parameter int          PKT_LEN = 1,
    parameter int          RATE    = 100,
    parameter int          PAT     = 0,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             start,
    output logic [A_W+D_W:0] m_axis_wdata,
    output logic             m_axis_wvalid,
    input  logic             m_axis_wready,
    output logic             m_axis_wlast,
    output logic             done,
    output logic [31:0]      sent_pkts
);

    localparam int          LOG2N    = $clog2(N);
    localparam int          RATE_C   = (RATE < 1) ? 1 : ((RATE > 100) ? 100 : RATE);
    localparam logic [7:0]  RATE_B   = 8'(RATE_C);
    localparam logic [15:0] SEED_C   = (SEED == 16'h0) ? 16'h0001 : SEED;
    localparam logic [8:0]  LAST_IDX = 9'(PKT_LEN - 1);
    localparam logic [31:0] LIMIT_C  = 32'(LIMIT);
    localparam logic [LOG2N-1:0] POSX_L = LOG2N'(POSX);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [7:0]       r_acc;
    logic             r_token;
    logic [15:0]      r_lfsr;
    logic [31:0]      r_launched;
    logic [8:0]       r_flit_idx;
    logic [D_W-1:0]   r_pay;
    logic [A_W+D_W:0] r_wdata;
    logic             r_valid;
    logic             r_last;
    logic             r_done;
    logic [31:0]      r_sent;

    logic             w_accept;
    logic             w_launch;
    logic             w_acc_en;
    logic [7:0]       w_sum;
    logic             w_hit;
    logic [D_W-1:0]   w_pay_base;
    logic [15:0]      w_lfsr_next;
    logic [LOG2N-1:0] w_sel;
    logic [A_W-1:0]   w_dest;

    // Handshake: a flit transfers on a clock where ce, wvalid and wready are all high;
    // wvalid, wdata and wlast are held unchanged until that happens.
    assign w_accept = r_valid & m_axis_wready & ce;
    assign w_launch = (r_state == S_RUN) & r_token & (r_launched < LIMIT_C)
                    & (!r_valid | (w_accept & r_last));

    // The accumulator also runs on the launch cycle so RATE=100 stays bubble-free.
    assign w_acc_en = (r_state == S_RUN) & (!r_token | w_launch);
    assign w_sum    = r_acc + RATE_B;
    assign w_hit    = (w_sum >= 8'd100);

    // Payload of the next flit equals the number of flits accepted so far this run.
    assign w_pay_base  = r_pay + D_W'(w_accept);
    assign w_lfsr_next = (r_lfsr >> 1) ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);

    always_comb begin
        w_sel = r_lfsr[LOG2N-1:0];
        if (PAT == 1)
            w_sel = ~POSX_L;
        else if (PAT == 2)
            w_sel = POSX_L + LOG2N'(1);
        else if (w_sel == POSX_L)
            w_sel = w_sel ^ LOG2N'(1);
    end

    assign w_dest = A_W'(w_sel);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_acc      <= 8'd0;
            r_token    <= 1'b0;
            r_lfsr     <= SEED_C;
            r_launched <= 32'd0;
            r_flit_idx <= 9'd0;
            r_pay      <= '0;
            r_wdata    <= '0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_done     <= 1'b0;
            r_sent     <= 32'd0;
        end else if (ce) begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_acc      <= 8'd0;
                        r_token    <= 1'b0;
                        r_launched <= 32'd0;
                        r_flit_idx <= 9'd0;
                        r_pay      <= '0;
                        r_sent     <= 32'd0;
                        r_valid    <= 1'b0;
                        r_last     <= 1'b0;
                        if (LIMIT_C == 32'd0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                            r_done  <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    if (w_acc_en) begin
                        r_token <= w_hit;
                        r_acc   <= w_hit ? (w_sum - 8'd100) : w_sum;
                    end
                    if (w_accept) begin
                        r_pay <= r_pay + D_W'(1);
                        if (r_last && r_sent != 32'hFFFF_FFFF)
                            r_sent <= r_sent + 32'd1;
                    end
                    if (w_launch) begin
                        r_valid    <= 1'b1;
                        r_flit_idx <= 9'd0;
                        r_last     <= (LAST_IDX == 9'd0);
                        r_wdata    <= {1'b1, w_dest, w_pay_base};
                        r_lfsr     <= w_lfsr_next;
                        r_launched <= r_launched + 32'd1;
                    end else if (w_accept && !r_last) begin
                        r_flit_idx           <= r_flit_idx + 9'd1;
                        r_last               <= ((r_flit_idx + 9'd1) == LAST_IDX);
                        r_wdata[D_W-1:0]     <= w_pay_base;
                    end else if (w_accept && r_last) begin
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        if (r_launched == LIMIT_C) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign m_axis_wdata  = r_wdata;
    assign m_axis_wvalid = r_valid;
    assign m_axis_wlast  = r_last;
    assign done          = r_done;
    assign sent_pkts     = r_sent;

endmodule

// File: tb/tb_bft_client_injector.sv
// Directed bench for bft_client_injector: four configurations share clock, reset and ce,
// each with its own start and ready.
module tb_bft_client_injector;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce  = 1'b1;

  int n_vec = 0;
  int n_err = 0;
  int d_seen = 0;

  // A: N=8 POSX=3 PAT=1 LIMIT=4 PKT_LEN=2 RATE=100 (dest 4)
  logic        st_a = 1'b0, rdy_a = 1'b1;
  logic [36:0] data_a;
  logic        val_a, last_a, done_a;
  logic [31:0] sent_a;
  // B: N=4 POSX=0 PAT=2 LIMIT=16 PKT_LEN=1 RATE=25 (dest 1)
  logic        st_b = 1'b0, rdy_b = 1'b1;
  logic [35:0] data_b;
  logic        val_b, last_b, done_b;
  logic [31:0] sent_b;
  // C: N=4 POSX=2 PAT=0 LIMIT=64 PKT_LEN=1 RATE=100
  logic        st_c = 1'b0, rdy_c = 1'b1;
  logic [35:0] data_c;
  logic        val_c, last_c, done_c;
  logic [31:0] sent_c;
  // D: N=2 LIMIT=0
  logic        st_d = 1'b0, rdy_d = 1'b1;
  logic [34:0] data_d;
  logic        val_d, last_d, done_d;
  logic [31:0] sent_d;

  bft_client_injector #(.N(8), .D_W(32), .POSX(3), .LIMIT(4), .PKT_LEN(2), .RATE(100), .PAT(1))
  u_a (.clk(clk), .rst(rst), .ce(ce), .start(st_a), .m_axis_wdata(data_a), .m_axis_wvalid(val_a),
       .m_axis_wready(rdy_a), .m_axis_wlast(last_a), .done(done_a), .sent_pkts(sent_a));

  bft_client_injector #(.N(4), .D_W(32), .POSX(0), .LIMIT(16), .PKT_LEN(1), .RATE(25), .PAT(2))
  u_b (.clk(clk), .rst(rst), .ce(ce), .start(st_b), .m_axis_wdata(data_b), .m_axis_wvalid(val_b),
       .m_axis_wready(rdy_b), .m_axis_wlast(last_b), .done(done_b), .sent_pkts(sent_b));

  bft_client_injector #(.N(4), .D_W(32), .POSX(2), .LIMIT(64), .PKT_LEN(1), .RATE(100), .PAT(0))
  u_c (.clk(clk), .rst(rst), .ce(ce), .start(st_c), .m_axis_wdata(data_c), .m_axis_wvalid(val_c),
       .m_axis_wready(rdy_c), .m_axis_wlast(last_c), .done(done_c), .sent_pkts(sent_c));

  bft_client_injector #(.N(2), .D_W(32), .POSX(0), .LIMIT(0), .PKT_LEN(1), .RATE(100), .PAT(2))
  u_d (.clk(clk), .rst(rst), .ce(ce), .start(st_d), .m_axis_wdata(data_d), .m_axis_wvalid(val_d),
       .m_axis_wready(rdy_d), .m_axis_wlast(last_d), .done(done_d), .sent_pkts(sent_d));

  always #5 clk = ~clk;

  always @(negedge clk) if (val_d === 1'b1) d_seen++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] fa(input int p);
    return (64'd1 << 36) | (64'd4 << 32) | 64'(p);
  endfunction

  function automatic logic [63:0] f36(input int d, input int p);
    return (64'd1 << 35) | (64'(d) << 32) | 64'(p);
  endfunction

  initial begin
    logic [15:0] lf;
    logic [1:0]  dm;
    int          cnt;
    logic        ev;

    // reset state
    step();
    step();
    chk("rst_val_a", val_a, 0);
    chk("rst_done_a", done_a, 0);
    chk("rst_data_a", data_a, 0);
    chk("rst_last_a", last_a, 0);
    chk("rst_sent_a", sent_a, 0);
    chk("rst_val_c", val_c, 0);
    chk("rst_data_c", data_c, 0);
    chk("rst_done_d", done_d, 0);
    rst = 1'b0;
    step();

    // 1: bit-complement, 4 packets x 2 flits, back-to-back
    st_a = 1'b1;
    step();
    st_a = 1'b0;
    chk("t1_val_e0", val_a, 0);
    step();
    chk("t1_val_e1", val_a, 0);
    step();
    for (int k = 0; k < 8; k++) begin
      chk("t1_val", val_a, 1);
      chk("t1_data", data_a, fa(k));
      chk("t1_last", last_a, (k % 2) == 1);
      chk("t1_sent", sent_a, k / 2);
      chk("t1_done", done_a, 0);
      step();
    end
    chk("t1_done_end", done_a, 1);
    chk("t1_val_end", val_a, 0);
    chk("t1_sent_end", sent_a, 4);

    // 2: backpressure on the third flit, restart from DONE
    st_a = 1'b1;
    step();
    st_a = 1'b0;
    chk("t2_done_clr", done_a, 0);
    chk("t2_sent_clr", sent_a, 0);
    step();
    step();
    chk("t2_f0", data_a, fa(0));
    step();
    chk("t2_f1", data_a, fa(1));
    step();
    chk("t2_f2", data_a, fa(2));
    rdy_a = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t2_hold_val", val_a, 1);
      chk("t2_hold_data", data_a, fa(2));
      chk("t2_hold_last", last_a, 0);
      chk("t2_hold_sent", sent_a, 1);
    end
    rdy_a = 1'b1;
    step();
    chk("t2_rel_data", data_a, fa(3));
    chk("t2_rel_last", last_a, 1);
    chk("t2_rel_sent", sent_a, 1);
    for (int k = 3; k < 8; k++) begin
      chk("t2_data", data_a, fa(k));
      step();
    end
    chk("t2_done", done_a, 1);
    chk("t2_sent", sent_a, 4);

    // 3: RATE=25, one flit every 4 cycles
    st_b = 1'b1;
    step();
    st_b = 1'b0;
    cnt = 0;
    for (int c = 1; c <= 68; c++) begin
      step();
      ev = (c >= 5) && (c <= 65) && (((c - 5) % 4) == 0);
      chk("t3_val", val_b, ev);
      if (val_b === 1'b1) begin
        chk("t3_data", data_b, f36(1, cnt));
        chk("t3_last", last_b, 1);
        cnt++;
      end
      chk("t3_done", done_b, c >= 66);
    end
    chk("t3_count", cnt, 16);
    chk("t3_sent", sent_b, 16);

    // 4: LFSR destinations against a reference model
    lf = 16'hACE1;
    st_c = 1'b1;
    step();
    st_c = 1'b0;
    cnt = 0;
    for (int c = 1; c <= 70; c++) begin
      step();
      chk("t4_val", val_c, (c >= 2) && (c <= 65));
      if (val_c === 1'b1) begin
        dm = lf[1:0];
        if (dm == 2'd2) dm = dm ^ 2'd1;
        chk("t4_data", data_c, f36(int'(dm), cnt));
        chk("t4_not_self", data_c[34:32] == 3'd2, 0);
        lf = (lf >> 1) ^ (lf[0] ? 16'hB400 : 16'h0000);
        cnt++;
      end
    end
    chk("t4_count", cnt, 64);
    chk("t4_done", done_c, 1);
    chk("t4_sent", sent_c, 64);

    // 5: asynchronous reset mid-packet
    st_a = 1'b1;
    step();
    st_a = 1'b0;
    step();
    step();
    chk("t5_pre_val", val_a, 1);
    chk("t5_pre_data", data_a, fa(0));
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_val", val_a, 0);
    chk("t5_rst_done", done_a, 0);
    chk("t5_rst_sent", sent_a, 0);
    chk("t5_rst_done_c", done_c, 0);
    #2;
    rst = 1'b0;
    step();
    st_a = 1'b1;
    step();
    st_a = 1'b0;
    step();
    step();
    chk("t5_restart_val", val_a, 1);
    chk("t5_restart_data", data_a, fa(0));

    // ce=0 for 3 cycles during RUN
    ce = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t6_ce_val", val_a, 1);
      chk("t6_ce_data", data_a, fa(0));
      chk("t6_ce_last", last_a, 0);
      chk("t6_ce_sent", sent_a, 0);
      chk("t6_ce_done", done_a, 0);
    end
    ce = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("t6_data", data_a, fa(k));
      chk("t6_last", last_a, (k % 2) == 1);
      step();
    end
    chk("t6_done_a", done_a, 1);
    chk("t6_sent_a", sent_a, 4);

    // 6: LIMIT=0
    st_d = 1'b1;
    step();
    st_d = 1'b0;
    chk("t6_lim0_done", done_d, 1);
    chk("t6_lim0_val", val_d, 0);
    step();
    step();
    chk("t6_lim0_hold", done_d, 1);
    chk("t6_lim0_sent", sent_d, 0);
    chk("t6_lim0_never", d_seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
